// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller and related decoders.
// Contents: RV32I major-opcode constants, FSM state and instruction-class
// encodings, datapath select codes and trap cause codes.
package ctrl_pkg;

  // RV32I major opcodes (instruction[6:0])
  localparam logic [6:0] rType  = 7'b0110011;
  localparam logic [6:0] iType  = 7'b0010011;
  localparam logic [6:0] lType  = 7'b0000011;
  localparam logic [6:0] sType  = 7'b0100011;
  localparam logic [6:0] sbType = 7'b1100011;
  localparam logic [6:0] uType  = 7'b0110111;
  localparam logic [6:0] ujType = 7'b1101111;
  localparam logic [6:0] auipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsL,
    ClsS,
    ClsSb,
    ClsU,
    ClsUj,
    ClsAuipc
  } cls_e;

  // alu_op codes
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluFunct  = 2'b01;
  localparam logic [1:0] AluBranch = 2'b10;
  localparam logic [1:0] AluUpper  = 2'b11;

  // mem_to_reg codes
  localparam logic [1:0] WbAlu  = 2'b00;
  localparam logic [1:0] WbLoad = 2'b01;
  localparam logic [1:0] WbPc4  = 2'b10;

  // pc_src codes
  localparam logic [1:0] PcPlus4  = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // trap_cause codes
  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseFetchTo = 2'b10;
  localparam logic [1:0] CauseDataTo  = 2'b11;

  // Width of a counter that must reach timeout-1; never narrower than 1 bit.
  function automatic int unsigned wait_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the multi-cycle controller and the datapath/memory side.
//   master: controller view (consumes instruction/mem_ready/branch_taken,
//           drives enables, selects, trap status and instret).
//   slave : datapath view (the mirror image).
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instruction;
  logic             mem_ready;
  logic             branch_taken;
  logic             ir_wrt;
  logic             pc_wrt;
  logic [1:0]       pc_src;
  logic             mem_rd;
  logic             mem_wrt;
  logic             i_or_d;
  logic             reg_wrt;
  logic             alu_src;
  logic             alu_a_pc;
  logic [1:0]       alu_op;
  logic [1:0]       mem_to_reg;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instruction, mem_ready, branch_taken,
    output ir_wrt, pc_wrt, pc_src, mem_rd, mem_wrt, i_or_d, reg_wrt, alu_src,
           alu_a_pc, alu_op, mem_to_reg, trap, trap_cause, instret
  );

  modport slave (
    output instruction, mem_ready, branch_taken,
    input  ir_wrt, pc_wrt, pc_src, mem_rd, mem_wrt, i_or_d, reg_wrt, alu_src,
           alu_a_pc, alu_op, mem_to_reg, trap, trap_cause, instret
  );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode classifier.
//   opcode  in  7  instruction[6:0]
//   cls     out    instruction class (ctrl_pkg::cls_e)
//   illegal out 1  opcode not supported (AUIPC illegal unless EN_AUIPC)
module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter bit EN_AUIPC = 1'b0
) (
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls     = ClsR;
    illegal = 1'b0;
    unique case (opcode)
      rType:  cls = ClsR;
      iType:  cls = ClsI;
      lType:  cls = ClsL;
      sType:  cls = ClsS;
      sbType: cls = ClsSb;
      uType:  cls = ClsU;
      ujType: cls = ClsUj;
      auipc: begin
        if (EN_AUIPC) cls = ClsAuipc;
        else          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a
// variable-latency memory handshake, sticky trap and retired-instruction count.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    master modport of multicycle_controller_if (inputs instruction,
//          mem_ready, branch_taken; outputs datapath enables/selects,
//          trap, trap_cause, instret)
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32,
  parameter bit          EN_AUIPC = 1'b0
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned WaitW = wait_width(TIMEOUT);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             retire;
  logic             timeout_hit;
  cls_e             dec_cls;
  logic             dec_illegal;

  // Only the opcode field matters to the controller.
  logic unused_instr_hi;
  assign unused_instr_hi = ^bus.instruction[31:7];

  opcode_classifier #(
    .EN_AUIPC(EN_AUIPC)
  ) u_classifier (
    .opcode (bus.instruction[6:0]),
    .cls    (dec_cls),
    .illegal(dec_illegal)
  );

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = wait_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (bus.mem_ready) begin
          state_d = StDecode;
          wait_d  = '0;
        end else if (timeout_hit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = CauseFetchTo;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        wait_d = '0;
        if (dec_illegal) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = CauseIllegal;
        end else begin
          cls_d   = dec_cls;
          state_d = StExecute;
        end
      end
      StExecute: begin
        unique case (cls_q)
          ClsSb: begin
            state_d = StFetch;
            retire  = 1'b1;
          end
          ClsL, ClsS: state_d = StMem;
          default:    state_d = StWriteback;
        endcase
      end
      StMem: begin
        if (bus.mem_ready) begin
          wait_d = '0;
          if (cls_q == ClsL) begin
            state_d = StWriteback;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = CauseDataTo;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWriteback: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Moore outputs; FETCH write enables are qualified by mem_ready, and the
  // SB branch enable follows branch_taken. While rst_n is low everything is 0
  // so no fetch request leaks out before reset is released.
  always_comb begin
    bus.ir_wrt     = 1'b0;
    bus.pc_wrt     = 1'b0;
    bus.pc_src     = PcPlus4;
    bus.mem_rd     = 1'b0;
    bus.mem_wrt    = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_wrt    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_a_pc   = 1'b0;
    bus.alu_op     = AluAdd;
    bus.mem_to_reg = WbAlu;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          bus.mem_rd = 1'b1;
          bus.ir_wrt = bus.mem_ready;
          bus.pc_wrt = bus.mem_ready;
        end
        StExecute: begin
          unique case (cls_q)
            ClsR: bus.alu_op = AluFunct;
            ClsI: begin
              bus.alu_src = 1'b1;
              bus.alu_op  = AluFunct;
            end
            ClsL, ClsS, ClsUj: bus.alu_src = 1'b1;
            ClsSb: begin
              bus.alu_op = AluBranch;
              bus.pc_wrt = bus.branch_taken;
              bus.pc_src = PcBranch;
            end
            ClsU: begin
              bus.alu_src = 1'b1;
              bus.alu_op  = AluUpper;
            end
            ClsAuipc: begin
              bus.alu_src  = 1'b1;
              bus.alu_a_pc = 1'b1;
              bus.alu_op   = AluUpper;
            end
          endcase
        end
        StMem: begin
          bus.i_or_d  = 1'b1;
          bus.mem_rd  = (cls_q == ClsL);
          bus.mem_wrt = (cls_q == ClsS);
        end
        StWriteback: begin
          bus.reg_wrt = 1'b1;
          if (cls_q == ClsL) begin
            bus.mem_to_reg = WbLoad;
          end else if (cls_q == ClsUj) begin
            bus.mem_to_reg = WbPc4;
            bus.pc_wrt     = 1'b1;
            bus.pc_src     = PcJump;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CauseNone;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes the expected control vector for every cycle
// in which the controller should drive something; per-DUT monitors pop and
// compare whenever a non-idle output vector appears on the bus.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) if_a ();
  multicycle_controller_if #(.CNT_W(32)) if_b ();

  multicycle_controller #(
    .TIMEOUT (16),
    .CNT_W   (32),
    .EN_AUIPC(1'b0)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_a),
    .bus  (if_a)
  );

  multicycle_controller #(
    .TIMEOUT (4),
    .CNT_W   (32),
    .EN_AUIPC(1'b1)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_b),
    .bus  (if_b)
  );

  typedef struct {
    logic [16:0] vec;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks   = 0;
  int failures = 0;

  // {ir_wrt,pc_wrt,pc_src,mem_rd,mem_wrt,i_or_d,reg_wrt,alu_src,alu_a_pc,alu_op,mem_to_reg,trap,cause}
  function automatic logic [16:0] ev(input logic ir, input logic pcw, input logic [1:0] pcs,
                                     input logic mrd, input logic mwr, input logic iod,
                                     input logic rw, input logic asrc, input logic apc,
                                     input logic [1:0] aop, input logic [1:0] m2r,
                                     input logic trp, input logic [1:0] cause);
    return {ir, pcw, pcs, mrd, mwr, iod, rw, asrc, apc, aop, m2r, trp, cause};
  endfunction

  function automatic logic [16:0] pack_a();
    return {if_a.ir_wrt, if_a.pc_wrt, if_a.pc_src, if_a.mem_rd, if_a.mem_wrt, if_a.i_or_d,
            if_a.reg_wrt, if_a.alu_src, if_a.alu_a_pc, if_a.alu_op, if_a.mem_to_reg,
            if_a.trap, if_a.trap_cause};
  endfunction

  function automatic logic [16:0] pack_b();
    return {if_b.ir_wrt, if_b.pc_wrt, if_b.pc_src, if_b.mem_rd, if_b.mem_wrt, if_b.i_or_d,
            if_b.reg_wrt, if_b.alu_src, if_b.alu_a_pc, if_b.alu_op, if_b.mem_to_reg,
            if_b.trap, if_b.trap_cause};
  endfunction

  task automatic compare(input string tag, input logic [16:0] gv, input logic [16:0] xv,
                         input logic [31:0] gc, input logic [31:0] xc);
    checks++;
    if (gv !== xv || gc !== xc) begin
      failures++;
      $display("FAIL %s: got ctrl=%05h instret=%0d, want ctrl=%05h instret=%0d",
               tag, gv, gc, xv, xc);
    end
  endtask

  // Monitors: every non-idle cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    logic [16:0] v;
    exp_t e;
    v = pack_a();
    if (v != '0) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected: got ctrl=%05h instret=%0d, want idle", v, if_a.instret);
      end else begin
        e = q_a.pop_front();
        compare({"a_", e.tag}, v, e.vec, if_a.instret, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] v;
    exp_t e;
    v = pack_b();
    if (v != '0) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected: got ctrl=%05h instret=%0d, want idle", v, if_b.instret);
      end else begin
        e = q_b.pop_front();
        compare({"b_", e.tag}, v, e.vec, if_b.instret, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input logic [31:0] ins, input logic rdy, input logic bt);
    if (s) begin
      if_b.instruction = ins; if_b.mem_ready = rdy; if_b.branch_taken = bt;
    end else begin
      if_a.instruction = ins; if_a.mem_ready = rdy; if_a.branch_taken = bt;
    end
  endtask

  task automatic push(input bit s, input logic [16:0] v, input logic [31:0] n, input string tag);
    exp_t e;
    e.vec = v;
    e.cnt = n;
    e.tag = tag;
    if (s) q_b.push_back(e);
    else   q_a.push_back(e);
  endtask

  task automatic check_idle(input bit s, input string tag);
    @(negedge clk);
    if (s) compare(tag, pack_b(), '0, if_b.instret, 32'd0);
    else   compare(tag, pack_a(), '0, if_a.instret, 32'd0);
    step();
  endtask

  // FETCH (with optional wait cycles) then a silent DECODE cycle in which
  // mem_ready/branch_taken are high and must be ignored.
  task automatic do_fetch(input bit s, input logic [31:0] ins, input int waits,
                          input logic [31:0] n);
    for (int i = 0; i < waits; i++) begin
      drive(s, ins, 1'b0, 1'b0);
      push(s, ev(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), n, "fetch_wait");
      step();
    end
    drive(s, ins, 1'b1, 1'b0);
    push(s, ev(1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), n, "fetch");
    step();
    drive(s, ins, 1'b1, 1'b1);
    step();
  endtask

  task automatic run_alu(input bit s, input logic [31:0] ins, input logic asrc, input logic apc,
                         input logic [1:0] aop, input int waits, input logic [31:0] n,
                         input string tag);
    do_fetch(s, ins, waits, n);
    drive(s, ins, 1'b1, 1'b1);
    push(s, ev(0, 0, 2'b00, 0, 0, 0, 0, asrc, apc, aop, 2'b00, 0, 2'b00), n, {tag, "_ex"});
    step();
    push(s, ev(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00), n, {tag, "_wb"});
    step();
  endtask

  task automatic run_mem(input bit s, input logic [31:0] ins, input bit is_load, input int waits,
                         input logic [31:0] n);
    do_fetch(s, ins, 0, n);
    push(s, ev(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00), n, "mem_ex");
    step();
    for (int i = 0; i <= waits; i++) begin
      drive(s, ins, (i == waits), 1'b0);
      push(s, ev(0, 0, 2'b00, is_load, !is_load, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), n,
           "mem_access");
      step();
    end
    if (is_load) begin
      drive(s, ins, 1'b0, 1'b0);
      push(s, ev(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 0, 2'b00), n, "load_wb");
      step();
    end
  endtask

  task automatic run_branch(input logic [31:0] ins, input logic bt, input logic [31:0] n);
    do_fetch(1'b0, ins, 0, n);
    drive(1'b0, ins, 1'b1, bt);
    push(1'b0, ev(0, bt, 2'b01, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00), n, "branch_ex");
    step();
  endtask

  task automatic run_jal(input logic [31:0] ins, input logic [31:0] n);
    do_fetch(1'b0, ins, 0, n);
    push(1'b0, ev(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00), n, "jal_ex");
    step();
    push(1'b0, ev(0, 1, 2'b10, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 0, 2'b00), n, "jal_wb");
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_idle(1'b0, "a_reset");
    check_idle(1'b1, "b_reset");

    // DUT A: TIMEOUT=16, AUIPC illegal
    rst_a = 1'b1;
    run_alu(1'b0, 32'h002081B3, 1'b0, 1'b0, 2'b01, 0, 0, "add");
    run_mem(1'b0, 32'h0020A183, 1'b1, 3, 1);
    run_branch(32'h00208063, 1'b1, 2);
    run_branch(32'h00208063, 1'b0, 3);
    run_jal(32'h000000EF, 4);
    run_mem(1'b0, 32'h0020A023, 1'b0, 1, 5);
    run_alu(1'b0, 32'h123452B7, 1'b1, 1'b0, 2'b11, 2, 6, "lui");
    run_alu(1'b0, 32'h00100093, 1'b1, 1'b0, 2'b01, 0, 7, "addi");

    do_fetch(1'b0, 32'h00000297, 0, 8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h00000297, 1'b1, 1'b1);
      push(1'b0, ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01), 8, "illegal_trap");
      step();
    end
    rst_a = 1'b0;
    check_idle(1'b0, "a_reset_after_illegal");
    rst_a = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      push(1'b0, ev(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), 0, "fetch_starve");
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      push(1'b0, ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10), 0, "fetch_timeout");
      step();
    end
    rst_a = 1'b0;
    check_idle(1'b0, "a_reset_after_timeout");
    rst_a = 1'b1;
    run_alu(1'b0, 32'h002081B3, 1'b0, 1'b0, 2'b01, 0, 0, "add_after_reset");
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    push(1'b0, ev(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), 1, "retire_count");
    step();
    rst_a = 1'b0;

    // DUT B: TIMEOUT=4, AUIPC enabled
    rst_b = 1'b1;
    run_alu(1'b1, 32'h00000297, 1'b1, 1'b1, 2'b11, 0, 0, "auipc");
    do_fetch(1'b1, 32'h0020A183, 0, 1);
    push(1'b1, ev(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00), 1, "lw_ex");
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0020A183, 1'b0, 1'b0);
      push(1'b1, ev(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), 1, "mem_starve");
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0020A183, 1'b1, 1'b0);
      push(1'b1, ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b11), 1, "data_timeout");
      step();
    end
    rst_b = 1'b0;
    step();
    step();

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got pending a=%0d b=%0d, want 0 0", q_a.size(), q_b.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. It handshakes with a variable-latency memory and generates per-state datapath enables. It also traps on illegal opcodes or memory timeouts and counts retired instructions. It sits between the instruction register/memory interface and the shared multi-cycle datapath.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for mem_ready in FETCH or MEM before trapping; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- EN_AUIPC, 0: 1 accepts opcode 0010111 as U-type with aluOp 2'b11 and alu_a_pc=1; 0 treats it as illegal.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- instruction  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory access complete this cycle.
- branch_taken  in  1  ALU branch condition, valid in EXECUTE.
- ir_wrt  out  1  load IR from memory data.
- pc_wrt  out  1  update PC.
- pc_src  out  2  PC source: 00 pc+4, 01 branch target, 10 jump target.
- mem_rd  out  1  memory read request.
- mem_wrt  out  1  memory write request.
- i_or_d  out  1  memory address: 0 PC, 1 ALU result.
- reg_wrt  out  1  register file write.
- alu_src  out  1  ALU operand B: 0 rs2, 1 immediate.
- alu_a_pc  out  1  ALU operand A: 0 rs1, 1 PC.
- alu_op  out  2  00 add, 01 funct-decoded, 10 branch compare, 11 upper immediate.
- mem_to_reg  out  2  writeback source: 00 ALU, 01 load data, 10 pc+4.
- trap  out  1  sticky fault indication.
- trap_cause  out  2  01 illegal opcode, 10 fetch timeout, 11 data timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n low): state=FETCH, class register=R, wait counter=0, instret=0, trap=0, trap_cause=00. All enables are 0 and all select outputs are 00.
- Outputs are Moore-style: decoded from the state and the registered class. Exception: ir_wrt and pc_wrt in FETCH, which are qualified by mem_ready.
- FETCH: mem_rd=1, i_or_d=0.
  - mem_ready=1: ir_wrt=1, pc_wrt=1, pc_src=00, go to DECODE.
  - Otherwise the wait counter increments. When the counter equals TIMEOUT-1 with no ready (TIMEOUT>0), go to TRAP with cause 10.
- DECODE: one cycle. Registers the class from instruction[6:0]: R, I, L, S, SB, U, UJ (plus AUIPC if enabled). An unknown opcode goes to TRAP with cause 01. Otherwise go to EXECUTE. Wait counter is cleared.
- EXECUTE: alu_src/alu_op per class: R 0/01, I 1/01, L 1/00, S 1/00, SB 0/10, U 1/11, UJ 1/00.
  - SB: pc_wrt=branch_taken, pc_src=01. Go to FETCH and retire.
  - L/S: go to MEM.
  - All other classes: go to WRITEBACK.
- MEM: i_or_d=1. Asserts mem_rd=1 for L or mem_wrt=1 for S, held until mem_ready.
  - On ready: L goes to WRITEBACK; S goes to FETCH and retires.
  - Timeout rule is the same as FETCH, with cause 11.
- WRITEBACK: reg_wrt=1. mem_to_reg is 01 for L, 10 for UJ, 00 otherwise.
  - UJ additionally drives pc_wrt=1, pc_src=10.
  - Go to FETCH and retire.
- Retire: instret increments by 1 on the retiring transition and wraps modulo 2^CNT_W.
- Cycle counts with zero-wait memory:
  - R/I/U: 4 cycles.
  - L: 5 cycles.
  - S: 4 cycles.
  - SB: 3 cycles.
  - UJ: 4 cycles.
- TRAP: all enables 0. trap=1 and trap_cause hold until reset; the block is absorbing.
- mem_ready outside FETCH/MEM is ignored.
- A reset asserted mid-instruction aborts it immediately, with no retire. The first fetch follows rst_n deassertion.
- Wait counter width is clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (iType, lType, rType, sType, sbType, uType, ujType, auipc);
  - the state encoding (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP);
  - the class encoding;
  - the alu_op, mem_to_reg and pc_src and trap_cause codes.
- One sub-module, opcode_classifier: combinational, opcode to {class, illegal}, honouring EN_AUIPC. It is reused by the future pipelined decoder.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready always 1: FETCH→DECODE→EXECUTE→WRITEBACK over 4 cycles. reg_wrt=1 only in cycle 4 with mem_to_reg=00. instret goes 0→1.
- lw with mem_ready delayed 3 cycles in MEM: mem_rd and i_or_d held for 4 cycles. WRITEBACK then shows mem_to_reg=01. Total 8 cycles.
- beq with branch_taken=1, then again with branch_taken=0: pc_wrt=1/pc_src=01 in EXECUTE for the first, pc_wrt=0 for the second. Each takes 3 cycles and retires.
- jal: WRITEBACK shows reg_wrt=1, mem_to_reg=10, pc_wrt=1, pc_src=10.
- Opcode 0010111 with EN_AUIPC=0: trap=1, cause 01 after DECODE. Repeat with EN_AUIPC=1: executes with alu_op=11, alu_a_pc=1.
- TIMEOUT=16 with mem_ready held low in FETCH: TRAP entered after exactly 16 FETCH cycles with cause 10. An rst_n pulse then returns to FETCH with instret=0 and trap=0.
